// File: rtl/ofm_packer.sv
// ofm_packer: gathers one output byte from each of 16 PE lanes into a
// 16-byte group, then streams the group out as four 32-bit words with a
// running word address. Lanes may finish in any order; a lane that reports
// again before its group has drained is dropped and flagged as overflow.

module ofm_packer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        OFM_0,
    input  logic [7:0]        OFM_1,
    input  logic [7:0]        OFM_2,
    input  logic [7:0]        OFM_3,
    input  logic [7:0]        OFM_4,
    input  logic [7:0]        OFM_5,
    input  logic [7:0]        OFM_6,
    input  logic [7:0]        OFM_7,
    input  logic [7:0]        OFM_8,
    input  logic [7:0]        OFM_9,
    input  logic [7:0]        OFM_10,
    input  logic [7:0]        OFM_11,
    input  logic [7:0]        OFM_12,
    input  logic [7:0]        OFM_13,
    input  logic [7:0]        OFM_14,
    input  logic [7:0]        OFM_15,
    input  logic [15:0]       valid,
    input  logic              addr_clr,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        laneMask_q, laneMask_d;
    logic [15:0][7:0]   slot_q, slot_d;
    logic [1:0]         wordIdx_q, wordIdx_d;
    logic [31:0]        outData_q, outData_d;
    logic [ADDR_W-1:0]  outAddr_q, outAddr_d;
    logic               outValid_q, outValid_d;
    logic               overflow_q, overflow_d;
    logic [15:0][7:0]   ofmBus;
    logic [3:0]         nextWordBase;

    assign ofmBus = {OFM_15, OFM_14, OFM_13, OFM_12,
                     OFM_11, OFM_10, OFM_9,  OFM_8,
                     OFM_7,  OFM_6,  OFM_5,  OFM_4,
                     OFM_3,  OFM_2,  OFM_1,  OFM_0};

    // Byte offset of the word that follows the one currently presented.
    assign nextWordBase = {wordIdx_q + 2'd1, 2'b00};

    // Next-state logic: capture lanes while collecting, step through the
    // four words while draining; output word is preloaded so out_data is
    // purely registered.
    always_comb begin
        state_d      = state_q;
        laneMask_d   = laneMask_q;
        slot_d       = slot_q;
        wordIdx_d    = wordIdx_q;
        outData_d    = outData_q;
        outAddr_d    = outAddr_q;
        outValid_d   = outValid_q;
        overflow_d   = overflow_q;

        case (state_q)
            COLLECT: begin
                for (int i = 0; i < 16; i++) begin
                    if (valid[i]) begin
                        if (!laneMask_q[i]) begin
                            slot_d[i]     = ofmBus[i];
                            laneMask_d[i] = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                if (addr_clr) begin
                    outAddr_d = '0;
                end
                if (&laneMask_d) begin
                    state_d    = DRAIN;
                    wordIdx_d  = 2'd0;
                    outValid_d = 1'b1;
                    outData_d  = slot_d[3:0];
                end
            end
            DRAIN: begin
                if (|valid) begin
                    overflow_d = 1'b1;
                end
                if (out_ready) begin
                    outAddr_d = outAddr_q + ADDR_W'(1);
                    if (wordIdx_q == 2'd3) begin
                        state_d    = COLLECT;
                        laneMask_d = '0;
                        outValid_d = 1'b0;
                        wordIdx_d  = 2'd0;
                    end else begin
                        wordIdx_d = wordIdx_q + 2'd1;
                        outData_d = slot_q[nextWordBase +: 4];
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State register with synchronous reset that discards any partial group.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            laneMask_q <= '0;
            slot_q     <= '0;
            wordIdx_q  <= 2'd0;
            outData_q  <= '0;
            outAddr_q  <= '0;
            outValid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            laneMask_q <= laneMask_d;
            slot_q     <= slot_d;
            wordIdx_q  <= wordIdx_d;
            outData_q  <= outData_d;
            outAddr_q  <= outAddr_d;
            outValid_q <= outValid_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data  = outData_q;
    assign out_addr  = outAddr_q;
    assign out_valid = outValid_q;
    assign busy      = (state_q == DRAIN);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ofm_packer.sv
// tb_ofm_packer: directed and random stimulus for ofm_packer with a
// group-level reference model feeding an expected-word queue, checked by
// an independent monitor.

module tb_ofm_packer;

    localparam int AW     = 3;
    localparam int ASPACE = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    ofm [16];
    logic [7:0]    nextOfm [16];
    logic [15:0]   laneValid;
    logic          addrClr;
    logic          outReady;
    logic [31:0]   outData;
    logic [AW-1:0] outAddr;
    logic          outValid;
    logic          busy;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    logic [63:0] expQ [$];
    logic [7:0]  mSlot [16];
    bit   [15:0] mMask    = '0;
    int          mPending = 0;
    int          mAddr    = 0;
    bit          mOvf     = 1'b0;
    bit          toggle;

    ofm_packer #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .OFM_0(ofm[0]),   .OFM_1(ofm[1]),   .OFM_2(ofm[2]),   .OFM_3(ofm[3]),
        .OFM_4(ofm[4]),   .OFM_5(ofm[5]),   .OFM_6(ofm[6]),   .OFM_7(ofm[7]),
        .OFM_8(ofm[8]),   .OFM_9(ofm[9]),   .OFM_10(ofm[10]), .OFM_11(ofm[11]),
        .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
        .valid(laneValid), .addr_clr(addrClr),
        .out_data(outData), .out_addr(outAddr), .out_valid(outValid),
        .out_ready(outReady), .busy(busy), .overflow(overflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Group-level model: a group completes when every lane has reported
    // once; its four words are then owed to the downstream side.
    task automatic modelStep(input bit rst, input logic [15:0] v, input bit clr, input bit rdy);
        if (rst) begin
            for (int i = 0; i < 16; i++) mSlot[i] = 8'h00;
            mMask    = '0;
            mPending = 0;
            mAddr    = 0;
            mOvf     = 1'b0;
            expQ.delete();
        end else if (mPending > 0) begin
            if (v != 16'h0) mOvf = 1'b1;
            if (rdy) begin
                mPending--;
                mAddr = (mAddr + 1) % ASPACE;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (v[i]) begin
                    if (mMask[i]) mOvf = 1'b1;
                    else begin
                        mSlot[i] = ofm[i];
                        mMask[i] = 1'b1;
                    end
                end
            end
            if (clr) mAddr = 0;
            if (mMask == 16'hFFFF) begin
                for (int k = 0; k < 4; k++)
                    expQ.push_back({32'((mAddr + k) % ASPACE),
                                    mSlot[4*k+3], mSlot[4*k+2], mSlot[4*k+1], mSlot[4*k]});
                mPending = 4;
                mMask    = '0;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input logic [15:0] v, input bit clr, input bit rdy);
        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(outValid), 32'(mPending > 0));
        checkOutput("busy", 32'(busy), 32'(mPending > 0));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        checkOutput("out_addr", 32'(outAddr), 32'(mAddr));
        reset     = rst;
        laneValid = v;
        addrClr   = clr;
        outReady  = rdy;
        for (int i = 0; i < 16; i++) ofm[i] = nextOfm[i];
        modelStep(rst, v, clr, rdy);
    endtask

    task automatic drainAll(input bit useToggle);
        for (int k = 0; k < 40 && mPending > 0; k++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, useToggle ? toggle : 1'b1);
            toggle = ~toggle;
        end
        checkOutput("drainDone", 32'(mPending), 32'd0);
    endtask

    // Monitor: whenever a word is presented it must match the oldest owed
    // word; it is retired only when a transfer will happen on the next edge.
    always @(negedge clk) begin
        if (reset === 1'b0 && outValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("wordOwed", 32'(expQ.size()), 32'd1);
            end else begin
                checkOutput("out_data", outData, expQ[0][31:0]);
                checkOutput("word_addr", 32'(outAddr), expQ[0][63:32]);
                if (outReady === 1'b1) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        laneValid = '0;
        addrClr   = 1'b0;
        outReady  = 1'b0;
        toggle    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ofm[i]     = 8'h00;
            nextOfm[i] = 8'h00;
            mSlot[i]   = 8'h00;
        end

        // Reset state
        applyStimulus(1'b1, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("resetData", outData, 32'h0);

        // All lanes in one cycle, bytes 1..16, ready held high
        for (int i = 0; i < 16; i++) nextOfm[i] = 8'(i + 1);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b1);
        drainAll(1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

        // One lane per cycle from 15 down to 0, ready toggling
        toggle = 1'b1;
        for (int lane = 15; lane >= 0; lane--) begin
            nextOfm[lane] = 8'($urandom);
            applyStimulus(1'b0, 16'(1) << lane, 1'b0, toggle);
            toggle = ~toggle;
        end
        drainAll(1'b1);

        // Lane 5 twice before completion, then lanes firing during drain
        nextOfm[5] = 8'hAA;
        applyStimulus(1'b0, 16'h0020, 1'b0, 1'b0);
        nextOfm[5] = 8'h55;
        applyStimulus(1'b0, 16'h0020, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) nextOfm[i] = 8'($urandom);
        applyStimulus(1'b0, 16'hFFDF, 1'b0, 1'b0);
        for (int k = 0; k < 8 && mPending > 0; k++) begin
            for (int i = 0; i < 16; i++) nextOfm[i] = 8'($urandom);
            applyStimulus(1'b0, 16'($urandom), 1'b0, 1'($urandom));
        end
        drainAll(1'b0);

        // Reset mid-drain after word 1, then a clean group from address 0
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b1);
        drainAll(1'b0);

        // Address advance, clear in collect, clear ignored in drain, wrap
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b1);
        drainAll(1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
        drainAll(1'b0);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b1);
        drainAll(1'b0);

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 16; i++) nextOfm[i] = 8'($urandom);
            applyStimulus($urandom_range(0, 199) == 0,
                          ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom & $urandom & $urandom),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 2) != 0);
        end
        drainAll(1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
